// File: rtl/alu_pkg.sv
// Shared types for the alu and its round-robin scheduler: op encoding,
// scheduler states and the datapath width.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_MUL = 3'b011,
    ALU_XOR = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_NOT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr,
// wrapping modulo N, receives a one-hot grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one alu between N_REQ requesters: round-robin grant, one op in
// flight, with a timeout on the alu ready and an error response for op 000.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_out,
  output logic                    rsp_carry,
  output logic                    rsp_err,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [OP_W-1:0]         alu_op,
  input  logic [DATA_W-1:0]       alu_out,
  input  logic                    alu_carry,
  input  logic                    alu_ready
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_e      state_q, state_n;
  logic [ID_W-1:0]   ptr_q, id_q, gnt_idx;
  logic [N_REQ-1:0]  grant;
  logic [DATA_W-1:0] a_q, b_q, out_q;
  logic [DATA_W-1:0] sel_a, sel_b;
  op_e               op_q, sel_op;
  logic              carry_q, err_q;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              req_fire, rsp_fire, timeout;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) gnt_idx = ID_W'(i);
    end
  end

  assign sel_a  = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_b  = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_op = op_e'(req_op[int'(gnt_idx)*OP_W +: OP_W]);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_n  = state_q;
    req_fire = 1'b0;
    rsp_fire = 1'b0;
    timeout  = 1'b0;
    cnt_n    = (cnt_q == CNT_W'(TIMEOUT_CYC)) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (|(req_valid & grant)) begin
          req_fire = 1'b1;
          state_n  = (sel_op == ALU_NOP) ? RESP : ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        // Ready wins over a timeout landing on the same edge.
        if (alu_ready) begin
          state_n = RESP;
        end else if (cnt_n == CNT_W'(TIMEOUT_CYC)) begin
          timeout = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[id_q]) begin
          rsp_fire = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign rsp_valid = (state_q == RESP) ? (N_REQ'(1) << id_q) : '0;
  assign rsp_out   = out_q;
  assign rsp_carry = carry_q;
  assign rsp_err   = err_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = (state_q == ISSUE || state_q == WAIT) ? op_q : ALU_NOP;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_NOP;
      out_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      if (req_fire) begin
        a_q   <= sel_a;
        b_q   <= sel_b;
        op_q  <= sel_op;
        id_q  <= gnt_idx;
        cnt_q <= '0;
        if (sel_op == ALU_NOP) begin
          out_q   <= '0;
          carry_q <= 1'b0;
          err_q   <= 1'b1;
        end
      end
      if (state_q == WAIT) begin
        if (alu_ready) begin
          out_q   <= alu_out;
          carry_q <= alu_carry;
          err_q   <= 1'b0;
        end else if (timeout) begin
          out_q   <= '0;
          carry_q <= 1'b0;
          err_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_n;
        end
      end
      if (rsp_fire) begin
        ptr_q <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural alu stub whose
// ready line can be held low to force timeouts.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a = '0;
  logic [N*32-1:0]   req_b = '0;
  logic [N*3-1:0]    req_op = '0;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '0;
  logic [31:0]       rsp_out;
  logic              rsp_carry, rsp_err;
  logic [31:0]       alu_a, alu_b, alu_out;
  logic [2:0]        alu_op;
  logic              alu_carry, alu_ready;
  logic              alu_en = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int nop_bad = 0;
  logic mon_nop = 1'b0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_ready (alu_ready)
  );

  // Behavioural alu: carry is the 33rd bit of add, the borrow of sub.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_op)
      ALU_ADD: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      ALU_MUL: alu_out = alu_a * alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_NOT: alu_out = ~alu_a;
      default: alu_out = '0;
    endcase
  end
  assign alu_ready = alu_en;

  always @(negedge clk) if (mon_nop && alu_op !== 3'b000) nop_bad++;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input op_e op);
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_op[id*3 +: 3]  = op;
  endtask

  // Raise req_valid[id], wait (bounded) for the grant, take the accept edge.
  // Leaves cyc=1, i.e. the first cycle after the accept edge.
  task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] b, input op_e op);
    int n = 0;
    set_req(id, a, b, op);
    req_valid[id] = 1'b1;
    #1;
    while (req_ready[id] !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (req_ready[id] !== 1'b1) begin
      errors++;
      $display("FAIL accept_req%0d: req_ready=%b required bit %0d", id, req_ready, id);
    end
    tick();
    req_valid[id] = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_rsp(input int id, input int bound);
    while (rsp_valid[id] !== 1'b1 && cyc < bound) tick();
  endtask

  task automatic finish_rsp(input int id);
    rsp_ready[id] = 1'b1;
    tick();
    rsp_ready[id] = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({req_ready, rsp_valid, rsp_out, rsp_carry, rsp_err, alu_a, alu_b, alu_op} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b rsp_out=%h carry=%b err=%b alu_a=%h alu_b=%h alu_op=%b required all zero",
               req_ready, rsp_valid, rsp_out, rsp_carry, rsp_err, alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_add();
    do_req(0, 32'd5, 32'd7, ALU_ADD);
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL add_early_rsp: rsp_valid=%b required 0000 in cycle 1", rsp_valid);
    end
    wait_rsp(0, 20);
    checks++;
    if (cyc != 3 || rsp_valid !== 4'b0001) begin
      errors++; $display("FAIL add_latency: cycle=%0d rsp_valid=%b required cycle 3 valid 0001", cyc, rsp_valid);
    end
    checks++;
    if ({rsp_out, rsp_carry, rsp_err} !== {32'd12, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_result: out=%h carry=%b err=%b required 0000000c 0 0", rsp_out, rsp_carry, rsp_err);
    end
    finish_rsp(0);
  endtask

  task automatic test_carry();
    do_req(1, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
    wait_rsp(1, 20);
    checks++;
    if ({rsp_valid, rsp_out, rsp_carry, rsp_err} !== {4'b0010, 32'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_carry: valid=%b out=%h carry=%b err=%b required 0010 00000000 1 0",
                         rsp_valid, rsp_out, rsp_carry, rsp_err);
    end
    finish_rsp(1);
    do_req(1, 32'd3, 32'd5, ALU_SUB);
    wait_rsp(1, 20);
    checks++;
    if ({rsp_valid, rsp_out, rsp_carry, rsp_err} !== {4'b0010, 32'hFFFF_FFFE, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_borrow: valid=%b out=%h carry=%b err=%b required 0010 fffffffe 1 0",
                         rsp_valid, rsp_out, rsp_carry, rsp_err);
    end
    finish_rsp(1);
  endtask

  task automatic test_round_robin();
    int multi = 0;
    int n;
    int exp_id;
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'(10 * i + 1), 32'd2, ALU_ADD);
    rsp_ready = '1;
    req_valid = '1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_id = k % N;
      n = 0;
      while (req_ready === '0 && n < 20) begin tick(); n++; end
      checks++;
      if (req_ready !== 4'(1 << exp_id)) begin
        errors++; $display("FAIL rr_grant%0d: req_ready=%b required one-hot bit %0d", k, req_ready, exp_id);
      end
      tick();
      n = 0;
      while (rsp_valid === '0 && n < 20) begin
        if (req_ready !== '0) multi++;
        tick(); n++;
      end
      checks++;
      if (rsp_valid !== 4'(1 << exp_id) || rsp_out !== 32'(10 * exp_id + 3)) begin
        errors++; $display("FAIL rr_rsp%0d: valid=%b out=%h required valid bit %0d out %h",
                           k, rsp_valid, rsp_out, exp_id, 32'(10 * exp_id + 3));
      end
      if (k == 5) req_valid = '0;
      tick();
    end
    rsp_ready = '0;
    checks++;
    if (multi != 0) begin
      errors++; $display("FAIL rr_busy_grant: %0d cycles with req_ready set while busy, required 0", multi);
    end
  endtask

  task automatic test_timeout();
    alu_en = 1'b0;
    do_req(3, 32'h10, 32'h20, ALU_ADD);
    wait_rsp(3, 40);
    checks++;
    if (cyc != TMO + 2 || {rsp_valid, rsp_out, rsp_carry, rsp_err} !== {4'b1000, 32'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL timeout: cycle=%0d valid=%b out=%h carry=%b err=%b required cycle %0d 1000 00000000 0 1",
                         cyc, rsp_valid, rsp_out, rsp_carry, rsp_err, TMO + 2);
    end
    finish_rsp(3);
    // Ready arrives in the last WAIT cycle: it must win over the timeout.
    do_req(0, 32'd100, 32'd23, ALU_ADD);
    for (int i = 0; i < TMO; i++) tick();
    alu_en = 1'b1;
    wait_rsp(0, 40);
    checks++;
    if (cyc != TMO + 2 || {rsp_valid, rsp_out, rsp_err} !== {4'b0001, 32'd123, 1'b0}) begin
      errors++; $display("FAIL ready_over_timeout: cycle=%0d valid=%b out=%h err=%b required cycle %0d 0001 0000007b 0",
                         cyc, rsp_valid, rsp_out, rsp_err, TMO + 2);
    end
    finish_rsp(0);
  endtask

  task automatic test_illegal_op();
    mon_nop = 1'b1;
    do_req(2, 32'd5, 32'd9, ALU_NOP);
    wait_rsp(2, 20);
    checks++;
    if (cyc != 1 || {rsp_valid, rsp_out, rsp_carry, rsp_err} !== {4'b0100, 32'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL illegal_op: cycle=%0d valid=%b out=%h carry=%b err=%b required cycle 1 0100 00000000 0 1",
                         cyc, rsp_valid, rsp_out, rsp_carry, rsp_err);
    end
    finish_rsp(2);
    tick();
    mon_nop = 1'b0;
    checks++;
    if (nop_bad != 0) begin
      errors++; $display("FAIL illegal_alu_op: alu_op nonzero on %0d cycles, required 0", nop_bad);
    end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    alu_en = 1'b0;
    do_req(1, 32'd6, 32'd7, ALU_MUL);
    tick();
    checks++;
    if (alu_op !== 3'b011) begin
      errors++; $display("FAIL mul_issue: alu_op=%b required 011 in WAIT", alu_op);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu_en = 1'b1;
    for (int i = 0; i < TMO + 6; i++) begin
      if (rsp_valid !== '0 || alu_op !== 3'b000) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_discard: %0d cycles with response or alu op after reset, required 0", seen);
    end
    for (int i = 0; i < N; i++) set_req(i, 32'(6 + i), 32'd7, ALU_ADD);
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_ptr: req_ready=%b required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    cyc = 1;
    wait_rsp(0, 20);
    checks++;
    if (cyc != 3 || rsp_out !== 32'd13) begin
      errors++; $display("FAIL post_reset_op: cycle=%0d out=%h required cycle 3 out 0000000d", cyc, rsp_out);
    end
    finish_rsp(0);
  endtask

  task automatic test_back_pressure();
    int unstable = 0;
    do_req(2, 32'h0000_F0F0, 32'h0000_0FF0, ALU_XOR);
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    wait_rsp(2, 20);
    checks++;
    if (cyc != 3 || {rsp_valid, rsp_out, rsp_carry, rsp_err} !== {4'b0100, 32'h0000_FF00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL xor_result: cycle=%0d valid=%b out=%h carry=%b err=%b required cycle 3 0100 0000ff00 0 0",
                         cyc, rsp_valid, rsp_out, rsp_carry, rsp_err);
    end
    for (int i = 0; i < 10; i++) begin
      rsp_ready[0] = i[0];
      rsp_ready[1] = 1'b1;
      tick();
      if ({rsp_valid, rsp_out, rsp_carry, rsp_err} !== {4'b0100, 32'h0000_FF00, 1'b0, 1'b0} || req_ready !== '0)
        unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL rsp_hold: %0d unstable or granting cycles while stalled, required 0", unstable);
    end
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL ptr_after_hold: req_ready=%b required 0001", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_round_robin();
    test_timeout();
    test_illegal_op();
    test_mid_reset();
    test_back_pressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
